smart_counter_ctrl: RTL and testbench

- Command sequencer that sits directly upstream of the 8-bit smart counter and drives its load/enable/data_in pins.
- Accepts LOAD and RUN commands over a valid/ready interface and converts them into cycle-exact load pulses or bounded enable windows.
- Observes the counter's count to flag wrap-around, and reports completion with a one-cycle done pulse.

---
 rtl/smart_counter_pkg.sv | 20 ++
 rtl/smart_counter_ctrl_if.sv | 14 +
 rtl/smart_counter_ctrl.sv | 94 +++++++++
 tb/tb_smart_counter_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smart_counter_pkg.sv
// Shared definitions for the smart counter command sequencer.
package smart_counter_pkg;

   localparam int unsigned CNT_WIDTH = 8;
   localparam int unsigned RUN_LEN_W = 8;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_LOAD = 2'b01,
      OP_RUN  = 2'b10
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/smart_counter_ctrl_if.sv
// Valid/ready command channel into the smart counter sequencer.
interface smart_counter_ctrl_if
   import smart_counter_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_WIDTH
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/smart_counter_ctrl.sv
// Turns LOAD/RUN commands into load pulses and bounded enable windows for the
// downstream 8-bit smart counter; flags imminent wrap and signals completion.
module smart_counter_ctrl
   import smart_counter_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_WIDTH,
   parameter int unsigned LEN_W = RUN_LEN_W
) (
   input  logic                 clk,
   input  logic                 reset,
   smart_counter_ctrl_if.slave  cmd,
   input  logic                 halt,
   input  logic [WIDTH-1:0]     count_in,
   output logic                 load_o,
   output logic                 enable_o,
   output logic [WIDTH-1:0]     data_o,
   output logic                 busy,
   output logic                 done,
   output logic                 wrap_evt
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             load_d, enable_d, done_d;
   logic [WIDTH-1:0] data_d;
   logic             accept_c;
   logic [LEN_W-1:0] run_len_c;

   assign cmd.cmd_ready = (state_q == S_IDLE) && reset;
   assign accept_c      = cmd.cmd_valid && cmd.cmd_ready;
   assign run_len_c     = cmd.cmd_data[LEN_W-1:0];
   assign busy          = (state_q != S_IDLE);
   assign wrap_evt      = enable_o && (count_in == {WIDTH{1'b1}});

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               case (cmd.cmd_op)
                  OP_LOAD: state_d = S_LOAD;
                  OP_RUN:  state_d = (run_len_c == '0) ? S_DONE : S_RUN;
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_LOAD:  state_d = S_DONE;
         S_RUN:   if (halt || rem_q == LEN_W'(1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: outputs are registered copies of what the next state implies
   always_comb begin
      load_d   = (state_d == S_LOAD);
      enable_d = (state_d == S_RUN);
      done_d   = (state_d == S_DONE);
      data_d   = data_o;
      rem_d    = rem_q;
      if (state_q == S_IDLE && accept_c && cmd.cmd_op == OP_LOAD) begin
         data_d = cmd.cmd_data;
      end
      if (state_q == S_IDLE && accept_c && cmd.cmd_op == OP_RUN) begin
         rem_d = run_len_c;
      end else if (state_q == S_RUN) begin
         rem_d = rem_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         load_o   <= 1'b0;
         enable_o <= 1'b0;
         done     <= 1'b0;
         data_o   <= '0;
         rem_q    <= '0;
      end else begin
         load_o   <= load_d;
         enable_o <= enable_d;
         done     <= done_d;
         data_o   <= data_d;
         rem_q    <= rem_d;
      end
   end

endmodule

// File: tb/tb_smart_counter_ctrl.sv
// Directed bench for smart_counter_ctrl driving a behavioural 8-bit counter.
module tb_smart_counter_ctrl;
   import smart_counter_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       halt;
   logic [7:0] count;
   logic       load_o, enable_o, busy, done, wrap_evt;
   logic [7:0] data_o;

   int n_checks = 0;
   int n_fail   = 0;

   smart_counter_ctrl_if #(.WIDTH(8)) bus ();

   smart_counter_ctrl #(.WIDTH(8), .LEN_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd      (bus.slave),
      .halt     (halt),
      .count_in (count),
      .load_o   (load_o),
      .enable_o (enable_o),
      .data_o   (data_o),
      .busy     (busy),
      .done     (done),
      .wrap_evt (wrap_evt)
   );

   always #5 clk = ~clk;

   // Reference counter: load has priority over enable
   always @(posedge clk) begin
      if (!reset)        count <= 8'd0;
      else if (load_o)   count <= data_o;
      else if (enable_o) count <= count + 8'd1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] d);
      int t;
      t = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      while (!bus.cmd_ready && t < 50) begin
         tick();
         t++;
      end
      if (!bus.cmd_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: cmd_ready=%0b required 1", bus.cmd_ready);
      end
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // Issue a command and observe until the controller returns to idle
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] d,
                          output int en_cyc, output int ld_cyc, output int dn_cyc,
                          output int wr_cyc, output logic [7:0] wr_cnt, output int overlap);
      int t;
      en_cyc = 0; ld_cyc = 0; dn_cyc = 0; wr_cyc = 0; wr_cnt = 8'h00; overlap = 0;
      send(op, d);
      t = 0;
      while (busy && t < 300) begin
         if (enable_o) en_cyc++;
         if (load_o) ld_cyc++;
         if (done) dn_cyc++;
         if (load_o && enable_o) overlap++;
         if (wrap_evt) begin wr_cyc++; wr_cnt = count; end
         tick();
         t++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL run_timeout: busy=%0b required 0", busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_op = 2'(OP_LOAD); bus.cmd_data = 8'h55;
      tick(); tick();
      n_checks++;
      if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b required 0", bus.cmd_ready); end
      n_checks++;
      if ({load_o, enable_o, done, busy} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_outputs: load/en/done/busy=%b required 0000", {load_o, enable_o, done, busy});
      end
      n_checks++;
      if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h required 00", data_o); end
      bus.cmd_valid = 1'b0;
      reset = 1'b1;
      tick();
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: ready=%0b busy=%0b required 1 0", bus.cmd_ready, busy);
      end
   endtask

   task automatic test_load_run();
      int en, ld, dn, wr, ov;
      logic [7:0] wc;
      send(2'(OP_LOAD), 8'd100);
      n_checks++;
      if (load_o !== 1'b1 || enable_o !== 1'b0 || data_o !== 8'd100 || bus.cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL load_cycle: load=%0b en=%0b data=%0d ready=%0b required 1 0 100 0",
                            load_o, enable_o, data_o, bus.cmd_ready);
      end
      tick();
      n_checks++;
      if (load_o !== 1'b0 || done !== 1'b1 || count !== 8'd100) begin
         n_fail++; $display("FAIL load_done: load=%0b done=%0b count=%0d required 0 1 100", load_o, done, count);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || bus.cmd_ready !== 1'b1 || data_o !== 8'd100) begin
         n_fail++; $display("FAIL load_idle: done=%0b ready=%0b data=%0d required 0 1 100", done, bus.cmd_ready, data_o);
      end
      run_cmd(2'(OP_RUN), 8'd2, en, ld, dn, wr, wc, ov);
      n_checks++;
      if (en !== 2 || dn !== 1 || ld !== 0 || count !== 8'd102) begin
         n_fail++; $display("FAIL run2: en=%0d done=%0d load=%0d count=%0d required 2 1 0 102", en, dn, ld, count);
      end
   endtask

   task automatic test_run_zero();
      send(2'(OP_RUN), 8'd0);
      n_checks++;
      if (done !== 1'b1 || enable_o !== 1'b0 || count !== 8'd102) begin
         n_fail++; $display("FAIL run0_done: done=%0b en=%0b count=%0d required 1 0 102", done, enable_o, count);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || enable_o !== 1'b0 || count !== 8'd102) begin
         n_fail++; $display("FAIL run0_idle: done=%0b busy=%0b en=%0b count=%0d required 0 0 0 102",
                            done, busy, enable_o, count);
      end
   endtask

   task automatic test_wrap();
      int en, ld, dn, wr, ov;
      logic [7:0] wc;
      run_cmd(2'(OP_LOAD), 8'hFF, en, ld, dn, wr, wc, ov);
      n_checks++;
      if (count !== 8'hFF || wrap_evt !== 1'b0) begin
         n_fail++; $display("FAIL wrap_idle: count=%h wrap=%0b required ff 0", count, wrap_evt);
      end
      run_cmd(2'(OP_LOAD), 8'hFE, en, ld, dn, wr, wc, ov);
      run_cmd(2'(OP_RUN), 8'd3, en, ld, dn, wr, wc, ov);
      n_checks++;
      if (en !== 3 || wr !== 1 || wc !== 8'hFF || count !== 8'h01 || ov !== 0) begin
         n_fail++; $display("FAIL wrap_run: en=%0d wraps=%0d wrap_at=%h count=%h overlap=%0d required 3 1 ff 01 0",
                            en, wr, wc, count, ov);
      end
   endtask

   task automatic test_halt();
      int en, ld, dn, wr, ov;
      logic [7:0] wc;
      // halt held during a LOAD must not disturb it
      halt = 1'b1;
      run_cmd(2'(OP_LOAD), 8'd0, en, ld, dn, wr, wc, ov);
      halt = 1'b0;
      n_checks++;
      if (ld !== 1 || dn !== 1 || count !== 8'd0) begin
         n_fail++; $display("FAIL halt_load: load=%0d done=%0d count=%0d required 1 1 0", ld, dn, count);
      end
      send(2'(OP_RUN), 8'd10);
      en = 0;
      for (int i = 0; i < 4; i++) begin
         if (enable_o) en++;
         if (i < 3) tick();
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      n_checks++;
      if (en !== 4 || enable_o !== 1'b0 || done !== 1'b1 || count !== 8'd4) begin
         n_fail++; $display("FAIL halt_edge: en=%0d en_now=%0b done=%0b count=%0d required 4 0 1 4",
                            en, enable_o, done, count);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || enable_o !== 1'b0 || count !== 8'd4) begin
         n_fail++; $display("FAIL halt_after: done=%0b busy=%0b en=%0b count=%0d required 0 0 0 4",
                            done, busy, enable_o, count);
      end
   endtask

   task automatic test_busy_reset();
      int en, t;
      logic early;
      send(2'(OP_RUN), 8'd5);
      bus.cmd_valid = 1'b1; bus.cmd_op = 2'(OP_LOAD); bus.cmd_data = 8'h33;
      en = 0; t = 0; early = 1'b0;
      while (!bus.cmd_ready && t < 50) begin
         if (enable_o) en++;
         if (load_o || data_o == 8'h33) early = 1'b1;
         tick();
         t++;
      end
      n_checks++;
      if (en !== 5 || early !== 1'b0 || count !== 8'd9 || bus.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL busy_block: en=%0d early=%0b count=%0d ready=%0b required 5 0 9 1",
                            en, early, count, bus.cmd_ready);
      end
      tick();
      bus.cmd_valid = 1'b0;
      n_checks++;
      if (load_o !== 1'b1 || data_o !== 8'h33) begin
         n_fail++; $display("FAIL busy_accept: load=%0b data=%h required 1 33", load_o, data_o);
      end
      tick(); tick();
      send(2'(OP_RUN), 8'd10);
      tick(); tick();
      reset = 1'b0;
      tick();
      n_checks++;
      if (enable_o !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL midrun_reset: en=%0b done=%0b busy=%0b ready=%0b required 0 0 0 0",
                            enable_o, done, busy, bus.cmd_ready);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if (done !== 1'b0 || enable_o !== 1'b0 || data_o !== 8'h00) begin
         n_fail++; $display("FAIL midrun_after: done=%0b en=%0b data=%h required 0 0 00", done, enable_o, data_o);
      end
   endtask

   initial begin
      reset = 1'b0;
      halt  = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = 8'h00;
      test_reset();
      test_load_run();
      test_run_zero();
      test_wrap();
      test_halt();
      test_busy_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
